jt900h_mul: RTL and testbench
=============================

// Module: jt900h_mul
// PURPOSE
// - Sequential shift-add multiplier for the TLCS-900H MUL/MULS instructions; arithmetic inverse of the divider.
// - Sits beside the ALU; the instruction sequencer pulses start, waits for busy to fall, then writes prod back to the register file.
// - Byte form: 8x8->16. Word form: 16x16->32. One partial product per enabled cycle.
// PARAMETERS
// - none; operand widths are fixed by the CPU ISA.
// PORTS
// - clk    in   1   system clock; single clock domain
// - rst_n  in   1   reset, synchronous, active-low
// - cen    in   1   clock enable; all state advances only when cen=1
// - op0    in   16  multiplicand; byte form uses op0[7:0]
// - op1    in   16  multiplier; byte form uses op1[7:0]
// - len    in   1   0=byte (8x8), 1=word (16x16)
// - sgn    in   1   1=signed (MULS); honoured only with JT900H_MULS_EN
// - start  in   1   load operands and begin; sampled when cen=1
// - prod   out  32  product; byte form drives prod[31:16]=0
// - busy   out  1   high from cycle after start until result valid
// - done   out  1   one-cen-cycle pulse when prod becomes valid
// - z      out  1   product==0, valid with done
// - s      out  1   MSB of product for selected length (prod[15] or prod[31])
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge, regardless of cen): prod=0, busy=0, done=0, z=0, s=0, state=IDLE, counter=0.
// - States: IDLE -> RUN -> [FIX] -> IDLE. done asserted on the cen cycle entering IDLE from RUN/FIX.
// - start (cen=1), any state: latch operands (byte form zero-extends op0/op1 [7:0]), acc=0, cnt=len?15:7, busy=1, done=0, go RUN. start during busy aborts and restarts; no done for the aborted op.
// - RUN, per cen=1 cycle: if multiplier LSB=1 add multiplicand to acc upper half; shift {acc,mult} right by 1 (carry into MSB); cnt-=1. At cnt==0 exit RUN.
// - Latency (unsigned): 8 cen cycles byte, 16 cen cycles word, counted from the start cycle exclusive; prod/z/s/done update on the last one and busy falls same edge.
// - Accumulator width: 17 bits to hold add carry; no overflow possible; unsigned product exact.
// - cen=0: full hold, including done (done stays high until next cen=1 edge).
// - z/s hold their last value until next done; prod holds until next start (cleared to 0 at start).
// CONFIGURATION
// - Macro JT900H_MULS_EN defined: sgn=1 takes |op0|,|op1| at start (two's complement per len), records sign = op0.msb ^ op1.msb; after RUN, FIX state negates prod within len when sign=1 -> latency +1 cen cycle (9/17). sgn=0 identical to unsigned timing.
// - Macro undefined: sgn ignored, FIX state not built, always unsigned.
// STRUCTURE
// - Shared package jt900h_pkg: state encoding (MUL_IDLE, MUL_RUN, MUL_FIX), length codes (LEN_BYTE=0, LEN_WORD=1).
// - One sub-module: jt900h_mul_neg (combinational conditional two's-complement on 32 bits with length select), used for operand abs and result negate.
// - Counter 4 bits; datapath registers: multiplicand 16, {acc,mult} 33.
// TESTING
// - len=0, op0=0xA5FF, op1=0x3CFF, sgn=0 -> prod=0x0000FE01, done 8 cen cycles after start, z=0, s=1.
// - len=1, op0=0xFFFF, op1=0xFFFF -> prod=0xFFFE0001 after 16 cycles, s=1; op0=0x1234, op1=0 -> prod=0, z=1.
// - JT900H_MULS_EN: len=1, sgn=1, op0=0xFFFF, op1=0x0002 -> prod=0xFFFFFFFE after 17 cycles; len=0, sgn=1, op0=0x80, op1=0x80 -> prod=0x00004000 after 9.
// - cen toggling 1-in-3 with len=1, op0=300, op1=700 -> prod=210000 (0x00033450); busy high for 48 clk, no change while cen=0.
// - start again 5 cycles into a word op (op0=3, op1=5, len=0) -> prod=15 after 8 cycles from second start, only one done pulse.
// - rst_n=0 for one edge mid-RUN -> busy=0, prod=0, done=0 next cycle; subsequent start behaves normally.

Source files
------------

// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h multiplier: FSM encoding, length codes,
// negate-width codes and result extraction helpers.
package jt900h_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_FIX  = 2'd2
    } mul_state_e;

    typedef enum logic [1:0] {
        NEG_W8  = 2'd0,
        NEG_W16 = 2'd1,
        NEG_W32 = 2'd2
    } neg_width_e;

    localparam logic       LEN_BYTE = 1'b0;
    localparam logic       LEN_WORD = 1'b1;
    localparam logic [3:0] CNT_BYTE = 4'd7;
    localparam logic [3:0] CNT_WORD = 4'd15;

    // A byte multiply stops after 8 shifts, leaving its 16-bit product at bits [23:8].
    function automatic logic [31:0] mul_result(input logic [31:0] am, input logic len);
        logic [31:0] r;
        if (len == LEN_WORD) begin
            r = am;
        end else begin
            r = {16'h0000, am[23:8]};
        end
        return r;
    endfunction

    function automatic logic mul_msb(input logic [31:0] p, input logic len);
        logic m;
        if (len == LEN_WORD) begin
            m = p[31];
        end else begin
            m = p[15];
        end
        return m;
    endfunction

endpackage

// File: rtl/jt900h_mul_neg.sv
// Conditional two's-complement negate of a 32-bit value within an 8/16/32-bit
// field; bits above the field are zeroed when negating.
module jt900h_mul_neg
    import jt900h_pkg::*;
(
    input  logic [31:0] val_i,
    input  logic        en_i,
    input  neg_width_e  width_i,
    output logic [31:0] val_o
);

    logic [31:0] neg_s;
    logic [31:0] res_s;

    // Negate and clip to the selected field width.
    always_comb begin
        neg_s = ~val_i + 32'd1;
        res_s = neg_s;
        case (width_i)
            NEG_W8:  res_s = {24'h000000, neg_s[7:0]};
            NEG_W16: res_s = {16'h0000, neg_s[15:0]};
            NEG_W32: res_s = neg_s;
            default: res_s = neg_s;
        endcase
        if (en_i) begin
            val_o = res_s;
        end else begin
            val_o = val_i;
        end
    end

endmodule

// File: rtl/jt900h_mul.sv
// Sequential shift-add multiplier for TLCS-900H MUL/MULS (8x8 and 16x16).
// Signed MULS support is built only when JT900H_MULS_EN is defined.
module jt900h_mul
    import jt900h_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [15:0] op0,
    input  logic [15:0] op1,
    input  logic        len,
    input  logic        sgn,
    input  logic        start,
    output logic [31:0] prod,
    output logic        busy,
    output logic        done,
    output logic        z,
    output logic        s
);

    mul_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mcand_q, mcand_d;
    logic [32:0] am_q, am_d;
    logic [31:0] prod_q, prod_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        z_q, z_d;
    logic        s_q, s_d;
    logic        len_q, len_d;

    logic [15:0] op0_ext, op1_ext;
    logic [31:0] op0_abs, op1_abs;
    logic        abs0_en, abs1_en;
    neg_width_e  opw;
    logic [16:0] sum17;
    logic [32:0] am_step;
    logic [31:0] res_run;
    logic        unused_abs_hi;

`ifdef JT900H_MULS_EN
    logic        sign_q, sign_d;
    logic        fix_q, fix_d;
    logic [31:0] fix_prod;
    neg_width_e  resw;

    assign abs0_en = sgn & ((len == LEN_WORD) ? op0[15] : op0[7]);
    assign abs1_en = sgn & ((len == LEN_WORD) ? op1[15] : op1[7]);
    assign resw    = (len_q == LEN_WORD) ? NEG_W32 : NEG_W16;

    jt900h_mul_neg u_neg_res (
        .val_i   (mul_result(am_q[31:0], len_q)),
        .en_i    (sign_q),
        .width_i (resw),
        .val_o   (fix_prod)
    );
`else
    logic unused_sgn;

    assign unused_sgn = sgn;
    assign abs0_en    = 1'b0;
    assign abs1_en    = 1'b0;
`endif

    assign op0_ext = (len == LEN_WORD) ? op0 : {8'h00, op0[7:0]};
    assign op1_ext = (len == LEN_WORD) ? op1 : {8'h00, op1[7:0]};
    assign opw     = (len == LEN_WORD) ? NEG_W16 : NEG_W8;

    jt900h_mul_neg u_neg_op0 (
        .val_i   ({16'h0000, op0_ext}),
        .en_i    (abs0_en),
        .width_i (opw),
        .val_o   (op0_abs)
    );

    jt900h_mul_neg u_neg_op1 (
        .val_i   ({16'h0000, op1_ext}),
        .en_i    (abs1_en),
        .width_i (opw),
        .val_o   (op1_abs)
    );

    assign unused_abs_hi = ^{op0_abs[31:16], op1_abs[31:16]};

    // One partial product: conditional add into the upper half, then shift right with carry.
    assign sum17   = am_q[32:16] + {1'b0, (am_q[0] ? mcand_q : 16'h0000)};
    assign am_step = {1'b0, sum17, am_q[15:1]};
    assign res_run = mul_result(am_step[31:0], len_q);

    // Next-state and datapath update; everything holds while cen is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        am_d    = am_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = done_q;
        z_d     = z_q;
        s_d     = s_q;
        len_d   = len_q;
`ifdef JT900H_MULS_EN
        sign_d  = sign_q;
        fix_d   = fix_q;
`endif
        if (cen) begin
            done_d = 1'b0;
            if (start) begin
                mcand_d = op0_abs[15:0];
                am_d    = {17'h00000, op1_abs[15:0]};
                cnt_d   = (len == LEN_WORD) ? CNT_WORD : CNT_BYTE;
                len_d   = len;
                prod_d  = 32'h00000000;
                busy_d  = 1'b1;
                state_d = MUL_RUN;
`ifdef JT900H_MULS_EN
                sign_d  = abs0_en ^ abs1_en;
                fix_d   = sgn;
`endif
            end else begin
                case (state_q)
                    MUL_IDLE: begin
                        state_d = MUL_IDLE;
                    end
                    MUL_RUN: begin
                        am_d = am_step;
                        if (cnt_q == 4'd0) begin
`ifdef JT900H_MULS_EN
                            if (fix_q) begin
                                state_d = MUL_FIX;
                            end else begin
                                prod_d  = res_run;
                                z_d     = (res_run == 32'h00000000);
                                s_d     = mul_msb(res_run, len_q);
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = MUL_IDLE;
                            end
`else
                            prod_d  = res_run;
                            z_d     = (res_run == 32'h00000000);
                            s_d     = mul_msb(res_run, len_q);
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = MUL_IDLE;
`endif
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
`ifdef JT900H_MULS_EN
                    MUL_FIX: begin
                        prod_d  = fix_prod;
                        z_d     = (fix_prod == 32'h00000000);
                        s_d     = mul_msb(fix_prod, len_q);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = MUL_IDLE;
                    end
`endif
                    default: begin
                        busy_d  = 1'b0;
                        state_d = MUL_IDLE;
                    end
                endcase
            end
        end else begin
            done_d = done_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            cnt_q   <= 4'd0;
            mcand_q <= 16'h0000;
            am_q    <= 33'h000000000;
            prod_q  <= 32'h00000000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
            len_q   <= LEN_BYTE;
`ifdef JT900H_MULS_EN
            sign_q  <= 1'b0;
            fix_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            am_q    <= am_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            s_q     <= s_d;
            len_q   <= len_d;
`ifdef JT900H_MULS_EN
            sign_q  <= sign_d;
            fix_q   <= fix_d;
`endif
        end
    end

    assign prod = prod_q;
    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign s    = s_q;

endmodule

// File: tb/tb_jt900h_mul.sv
// Self-checking bench for jt900h_mul: vector table, randomized ops against an
// arithmetic reference model, and hand-written cen/restart/reset sequences.
module tb_jt900h_mul;

`ifdef JT900H_MULS_EN
    localparam bit MULS = 1'b1;
`else
    localparam bit MULS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, cen, len, sgn, start;
    logic [15:0] op0, op1;
    logic [31:0] prod;
    logic        busy, done, z, s;

    int checks   = 0;
    int failures = 0;

    jt900h_mul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .op0   (op0),
        .op1   (op1),
        .len   (len),
        .sgn   (sgn),
        .start (start),
        .prod  (prod),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .s     (s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        l;
        logic [31:0] p;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                             input logic l, input logic sg);
        longint x, y, p;
        logic [7:0] a8, b8;
        a8 = a[7:0];
        b8 = b[7:0];
        if (l) begin
            x = longint'(a);
            y = longint'(b);
            if (MULS && sg) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end
        end else begin
            x = longint'(a8);
            y = longint'(b8);
            if (MULS && sg) begin
                x = longint'($signed(a8));
                y = longint'($signed(b8));
            end
        end
        p = x * y;
        if (l) return p[31:0];
        return {16'h0000, p[15:0]};
    endfunction

    function automatic int ref_lat(input logic l, input logic sg);
        return (l ? 16 : 8) + ((MULS && sg) ? 1 : 0);
    endfunction

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic l, input logic sg, input logic [31:0] ep, input int elat);
        int n;
        op0 = a; op1 = b; len = l; sgn = sg; start = 1'b1; cen = 1'b1;
        tick();
        start = 1'b0;
        chk({name, " busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({name, " prod_cleared"}, prod, 32'd0);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk({name, " latency"}, n, elat);
        chk({name, " prod"}, prod, ep);
        chk({name, " z"}, {31'd0, z}, {31'd0, (ep == 32'd0)});
        chk({name, " s"}, {31'd0, s}, {31'd0, (l ? ep[31] : ep[15])});
        chk({name, " busy_fall"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t vt[6];
        logic [15:0] ra, rb;
        logic        rl, rs;
        int          nclk, bclk, bad, ndone, n;
        logic [31:0] held;

        vt[0] = '{a: 16'hA5FF, b: 16'h3CFF, l: 1'b0, p: 32'h0000FE01};
        vt[1] = '{a: 16'hFFFF, b: 16'hFFFF, l: 1'b1, p: 32'hFFFE0001};
        vt[2] = '{a: 16'h1234, b: 16'h0000, l: 1'b1, p: 32'h00000000};
        vt[3] = '{a: 16'd300,  b: 16'd700,  l: 1'b1, p: 32'h00033450};
        vt[4] = '{a: 16'h0003, b: 16'h0005, l: 1'b0, p: 32'h0000000F};
        vt[5] = '{a: 16'h0001, b: 16'hFFFF, l: 1'b1, p: 32'h0000FFFF};

        rst_n = 1'b0; cen = 1'b0; start = 1'b0; op0 = 16'h0; op1 = 16'h0; len = 1'b0; sgn = 1'b0;
        tick(); tick(); tick();
        chk("reset prod", prod, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset z", {31'd0, z}, 32'd0);
        chk("reset s", {31'd0, s}, 32'd0);
        rst_n = 1'b1;
        cen = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].l, 1'b0, vt[i].p, ref_lat(vt[i].l, 1'b0));
        end

`ifdef JT900H_MULS_EN
        run_op("muls_word", 16'hFFFF, 16'h0002, 1'b1, 1'b1, 32'hFFFFFFFE, 17);
        run_op("muls_byte", 16'h0080, 16'h0080, 1'b0, 1'b1, 32'h00004000, 9);
`endif

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rl = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), ra, rb, rl, rs, ref_prod(ra, rb, rl, rs), ref_lat(rl, rs));
        end

        // cen asserted one clock in three during a word multiply
        op0 = 16'd300; op1 = 16'd700; len = 1'b1; sgn = 1'b0; start = 1'b1; cen = 1'b1;
        tick();
        start = 1'b0;
        nclk = 0; bclk = {31'd0, busy}; bad = 0;
        while (!done && nclk < 200) begin
            cen = ((nclk % 3) == 2);
            tick();
            nclk++;
            if (busy) bclk++;
            if (!done && prod != 32'd0) bad++;
        end
        chk("cen3 clocks", nclk, 48);
        chk("cen3 busy_clocks", bclk, 48);
        chk("cen3 prod_stable", bad, 0);
        chk("cen3 prod", prod, 32'd210000);
        held = prod;
        cen = 1'b0;
        tick(); tick();
        chk("cen3 done_held", {31'd0, done}, 32'd1);
        chk("cen3 prod_held", prod, held);
        cen = 1'b1;
        tick();
        chk("cen3 done_drop", {31'd0, done}, 32'd0);

        // restart mid-operation: only the second op completes
        op0 = 16'h1111; op1 = 16'h2222; len = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) ndone++;
        end
        op0 = 16'd3; op1 = 16'd5; len = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("restart latency", n, 8);
        chk("restart prod", prod, 32'd15);
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("restart done_count", ndone, 1);

        // reset for one edge in the middle of a multiply
        op0 = 16'hFFFF; op1 = 16'hFFFF; len = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset prod", prod, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) n++;
        end
        chk("midreset no_done", n, 0);
        run_op("post_reset", 16'h00C8, 16'h0019, 1'b0, 1'b0, 32'h00001388, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
